// File: rtl/lab_bcd_pkg.sv
// lab_bcd_pkg: shared types and constants for the sequential BCD-to-binary converter.
// Rev 1.0
`default_nettype none

package lab_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] CORR          = 4'd3;
  localparam logic [3:0] CORR_THRESH   = 4'd8;

  // Minimum binary width able to hold 10**ndigits - 1.
  function automatic int bin_width(input int ndigits);
    longint v;
    v = 1;
    for (int i = 0; i < ndigits; i++) begin
      v = v * 10;
    end
    return $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/done handshake and data bus of the BCD-to-binary converter.
// Rev 1.0
`default_nettype none

interface bcd_to_bin_seq_if #(
  parameter int NDIGITS = 2,
  parameter int BIN_W   = 7
);
  logic                   start;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic                   busy;
  logic                   done;
  logic [BIN_W-1:0]       bin_out;
  logic                   err;

  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

`default_nettype wire

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3: per-digit correction for reverse double-dabble (d>=8 ? d-3 : d).
// Rev 1.0
`default_nettype none

module bcd_digit_sub3
  import lab_bcd_pkg::*;
(
  input  wire logic [3:0] d_i,
  output logic      [3:0] d_o
);

  assign d_o = (d_i >= CORR_THRESH) ? (d_i - CORR) : d_i;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one bit per clock, start/done handshake.
// Rev 1.0 -- optional digit-range check enabled by defining BCD2BIN_ERRCHK_EN.
`default_nettype none

module bcd_to_bin_seq
  import lab_bcd_pkg::*;
#(
  parameter int NDIGITS = 2,
  parameter int BIN_W   = bin_width(NDIGITS)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int SW    = 4 * NDIGITS;
  localparam int CNT_W = $clog2(SW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SW - 1);

  state_t             state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [SW-1:0]      b_q, b_d;
  logic [SW-1:0]      s_shr;
  logic [SW-1:0]      s_cor;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   res;
  logic               done_q, done_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = (state_q != IDLE);
  end

  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;

  // Shift the digit register right, then pull each digit back into BCD range.
  assign s_shr = s_q >> 1;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .d_i (s_shr[4*i +: 4]),
      .d_o (s_cor[4*i +: 4])
    );
  end

  // The accumulator holds the full value after SW shifts; fit it to BIN_W.
  if (BIN_W <= SW) begin : g_res_trunc
    assign res = b_q[BIN_W-1:0];
  end else begin : g_res_ext
    assign res = {{(BIN_W - SW){1'b0}}, b_q};
  end

  always_comb begin
    s_d    = s_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d   = bus.bcd_in;
          b_d   = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        s_d   = s_cor;
        b_d   = {s_q[0], b_q[SW-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: begin
        bin_d  = res;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      bin_q  <= '0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      done_q <= done_d;
    end
  end

`ifdef BCD2BIN_ERRCHK_EN
  logic digit_bad;
  logic errp_q, errp_d;
  logic err_q, err_d;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > BCD_MAX_DIGIT) digit_bad = 1'b1;
    end
  end

  // Flag is captured at accept and published together with bin_out.
  always_comb begin
    errp_d = errp_q;
    err_d  = err_q;
    if ((state_q == IDLE) && bus.start) errp_d = digit_bad;
    if (state_q == DONE) err_d = errp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errp_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      errp_q <= errp_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq (NDIGITS=2, BIN_W=7).
// Rev 1.0
`default_nettype none

module tb_bcd_to_bin_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_to_bin_seq_if #(.NDIGITS(2), .BIN_W(7)) bus ();

  bcd_to_bin_seq #(.NDIGITS(2), .BIN_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One conversion; optional stray start pulse (bcd 12) before edge glitch_cyc after accept.
  task automatic conv(input string tag, input logic [7:0] bcd, input logic [6:0] exp_bin,
                      input logic exp_err, input logic chk_bin, input int glitch_cyc);
    int lat;
    int ndone;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat   = 0;
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == glitch_cyc) begin
        bus.start  = 1'b1;
        bus.bcd_in = 8'h12;
      end else begin
        bus.start  = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        end
      end
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    if (chk_bin) chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    int ndone;
    int first;
    int last;
    int gap_ok;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bin",  32'(bus.bin_out), 32'd0);
    chk("rst_err",  32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv("c45", 8'h45, 7'd45, 1'b0, 1'b1, 0);
    conv("c99", 8'h99, 7'd99, 1'b0, 1'b1, 0);
    conv("c00", 8'h00, 7'd0,  1'b0, 1'b1, 0);
    conv("c90", 8'h90, 7'd90, 1'b0, 1'b1, 0);
    conv("c08", 8'h08, 7'd8,  1'b0, 1'b1, 0);
    conv("ign_busy", 8'h45, 7'd45, 1'b0, 1'b1, 3);
    conv("ign_done", 8'h67, 7'd67, 1'b0, 1'b1, 9);

    // Reset four edges into a conversion
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h37;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bin",  32'(bus.bin_out), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv("c37", 8'h37, 7'd37, 1'b0, 1'b1, 0);

`ifdef BCD2BIN_ERRCHK_EN
    conv("errA5", 8'hA5, 7'd0, 1'b1, 1'b0, 0);
    conv("err05", 8'h05, 7'd5, 1'b0, 1'b1, 0);
`endif

    // start held high: accepts at edges 0,10,20,30 -> done at 9,19,29
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h21;
    @(posedge clk);
    #1;
    ndone  = 0;
    first  = 0;
    last   = 0;
    gap_ok = 1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (ndone == 0) first = i;
        else if (i - last != 10) gap_ok = 0;
        last = i;
        ndone++;
        chk("held_bin", 32'(bus.bin_out), 32'd21);
      end
    end
    bus.start = 1'b0;
    chk("held_ndone", 32'(ndone), 32'd3);
    chk("held_first", 32'(first), 32'd9);
    chk("held_gap",   32'(gap_ok), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("held_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
